sel_bus_sched: RTL and testbench
================================

Name: sel_bus_sched

Overview:
- Scheduler for the shared decoded-select observation bus. That bus is the 8-bit select code (g6, g7, g8, g9, g16, g19, g28, g31), which picks one of several status sources onto a single result bit, gated by an update strobe.
- Several requesters each need the value behind a given code. This block arbitrates between them round-robin and drives one code at a time.
- For each granted request it waits a programmable settle latency, strobes the capture, samples the result and returns it to the winner.
- Sits between requesting control FSMs and the combinational select/decode cone.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CODE_W, 8, select-code width.
- LAT, 2, settle cycles between code-drive and sample (>=1).
- PARK_CODE, 8'h00, code driven while idle.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_code  in  NREQ*CODE_W  requested select code; requester i uses slice [i*CODE_W +: CODE_W].
- req_ready  out  NREQ  accept; combinational, at most one bit set.
- rsp_valid  out  NREQ  one-cycle response pulse to the original requester.
- rsp_data  out  1  sampled result; valid only while rsp_valid is nonzero.
- sel_code  out  CODE_W  registered code driven to the decode cone.
- sel_en  out  1  capture/update strobe to the datapath (plays the g35 role).
- bus_data  in  1  decoded result bit from the datapath.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state = IDLE, ptr = 0, cnt = 0.
  - sel_code = PARK_CODE; sel_en, rsp_valid, rsp_data, busy all 0.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- States: IDLE, WAIT, SAMPLE, RESP.
- IDLE:
  - w = first i with req_valid[i]=1, searching ptr, ptr+1, ... (mod NREQ).
  - req_ready[w] = 1 combinationally; all other req_ready bits are 0.
  - If any req_valid is set: handshake completes this cycle (t).
  - At the clock edge: sel_code <= req_code[w], gnt <= w, cnt <= LAT-1, go to WAIT.
  - If no req_valid is set: sel_code stays PARK_CODE.
- WAIT:
  - sel_code held stable.
  - cnt decrements each cycle; when cnt == 0, go to SAMPLE.
  - WAIT occupies cycles t+1 .. t+LAT.
- SAMPLE (cycle t+LAT+1):
  - sel_en = 1 for exactly this cycle.
  - data_q <= bus_data at the clock edge.
  - Go to RESP.
- RESP (cycle t+LAT+2):
  - rsp_valid[gnt] = 1 and rsp_data = data_q.
  - At the edge: ptr <= (gnt+1) mod NREQ, sel_code <= PARK_CODE, go to IDLE.
- Throughput: one transaction per LAT+3 cycles. req_ready is 0 in every state except IDLE.
- Requester rules:
  - Hold req_valid and req_code until accepted.
  - Deasserting req_valid before acceptance is legal; no transaction results.
  - A requester may re-request in the same cycle its rsp_valid pulses; it is then seen in the next IDLE cycle, subject to the rotated pointer.
- Simultaneous requests: only the winner is accepted; losers keep waiting, with no starvation (worst wait is NREQ-1 transactions).
- ptr wraps from NREQ-1 to 0.
- req_code equal to PARK_CODE is legal and is processed normally.

Decomposition:
- Package sel_bus_pkg:
  - state enum {IDLE, WAIT, SAMPLE, RESP}.
  - CODE_W and PARK_CODE defaults.
  - Bit-position constants for the code fields: 6, 7, 8, 9, 16, 19, 28, 31 mapped to code[0..7].
- One sub-module, rr_arbiter (NREQ): inputs req and ptr; outputs one-hot gnt and index gnt_idx; purely combinational.

Test Plan:
- Single request, LAT=2: req_valid=4'b0001, req_code[0]=8'h5A, bus_data=1 at SAMPLE.
  - Required: ready at t; sel_code=8'h5A during t+1..t+3.
  - sel_en=1 at t+3 only; rsp_valid=4'b0001 with rsp_data=1 at t+4; sel_code=8'h00 at t+5.
- All four requesting continuously from reset: grants follow order 0,1,2,3,0. Each transaction takes 5 cycles and each rsp_valid goes to the matching bit.
- Pointer rotation: after a grant to 2, req_valid=4'b0101 -> requester 0 is granted (search starts at 3, wraps to 0).
- Reset mid-WAIT: assert RST at t+2. Required the same cycle (async): sel_code=8'h00, busy=0, sel_en=0. After release, no rsp_valid is issued and ptr=0.
- Withdrawn request: while busy, requester 1 raises then drops req_valid before IDLE -> no grant and no response for requester 1.
- bus_data toggles during WAIT and is 0 in the SAMPLE cycle -> rsp_data=0, i.e. only the SAMPLE-cycle value is captured.

Source files
------------

// File: rtl/sel_bus_pkg.sv
// Shared types and constants for the select-bus scheduler.
// Holds the FSM state encoding and the select-code field positions.
package sel_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        RESP
    } state_e;

    localparam int DEF_CODE_W = 8;
    localparam logic [7:0] DEF_PARK_CODE = 8'h00;

    // code[k] drives select line g<SEL_BIT_POS[k]>
    localparam int SEL_BIT_POS [8] = '{6, 7, 8, 9, 16, 19, 28, 31};

endpackage

// File: rtl/sel_bus_sched_if.sv
// Request/response and decode-cone signals of the select-bus scheduler.
// slave is the scheduler side, master the requester/datapath side.
interface sel_bus_sched_if #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 8
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic                   rsp_data;
    logic [CODE_W-1:0]      sel_code;
    logic                   sel_en;
    logic                   bus_data;
    logic                   busy;

    modport slave (
        input  req_valid, req_code, bus_data,
        output req_ready, rsp_valid, rsp_data,
        output sel_code, sel_en, busy
    );

    modport master (
        output req_valid, req_code, bus_data,
        input  req_ready, rsp_valid, rsp_data,
        input  sel_code, sel_en, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr.
// Returns the winner one-hot and as an index; all zero when nothing requests.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    always_comb begin
        int  i;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            i = int'(ptr) + k;
            if (i >= NREQ) i = i - NREQ;
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/sel_bus_sched.sv
// Round-robin scheduler for the shared decoded-select observation bus.
// Drives one code, waits LAT cycles, strobes capture and returns the bit.
module sel_bus_sched
    import sel_bus_pkg::*;
#(
    parameter int                NREQ      = 4,
    parameter int                CODE_W    = DEF_CODE_W,
    parameter int                LAT       = 2,
    parameter logic [CODE_W-1:0] PARK_CODE = CODE_W'(DEF_PARK_CODE)
) (
    input  logic           CK,
    input  logic           RST,
    sel_bus_sched_if.slave bus
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CODE_W-1:0] sel_code_q, sel_code_d;
    logic              data_q, data_d;
    logic [NREQ-1:0]   arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [CODE_W-1:0] win_code;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign win_code     = bus.req_code[int'(arb_idx)*CODE_W +: CODE_W];
    assign bus.sel_code = sel_code_q;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            sel_code_q <= PARK_CODE;
            data_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            sel_code_q <= sel_code_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        sel_code_d = sel_code_q;
        data_d     = data_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d    = WAIT;
                    gnt_d      = arb_idx;
                    cnt_d      = CW'(LAT - 1);
                    sel_code_d = win_code;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            SAMPLE: begin
                data_d  = bus.bus_data;
                state_d = RESP;
            end
            RESP: begin
                state_d    = IDLE;
                sel_code_d = PARK_CODE;
                // next search starts just past the requester served last
                ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = 1'b0;
        bus.sel_en    = 1'b0;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            IDLE:   bus.req_ready = arb_gnt;
            SAMPLE: bus.sel_en    = 1'b1;
            RESP: begin
                bus.rsp_valid[gnt_q] = 1'b1;
                bus.rsp_data         = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sel_bus_sched.sv
// Directed self-checking bench for sel_bus_sched (NREQ=4, LAT=2).
// Each cycle: inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_sel_bus_sched;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   exp_g [5] = '{0, 1, 2, 3, 0};

    sel_bus_sched_if #(.NREQ(4), .CODE_W(8)) bus ();

    sel_bus_sched #(
        .NREQ      (4),
        .CODE_W    (8),
        .LAT       (2),
        .PARK_CODE (8'h00)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge CK);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_code  = {8'h13, 8'h12, 8'h11, 8'h5A};
        bus.bus_data  = 1'b0;

        // reset state
        #2;
        chk("rst_sel_code", bus.sel_code, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_sel_en", bus.sel_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_rsp_data", bus.rsp_data, 1'b0);
        chk("rst_ready", bus.req_ready, 4'b0000);
        nxt();
        RST = 1'b0;

        // single request from requester 0
        nxt();
        bus.req_valid = 4'b0001;
        #1;
        chk("t0_ready", bus.req_ready, 4'b0001);
        chk("t0_busy", bus.busy, 1'b0);
        nxt();
        bus.req_valid = 4'b0000;
        #1;
        chk("t1_sel_code", bus.sel_code, 8'h5A);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_ready", bus.req_ready, 4'b0000);
        chk("t1_sel_en", bus.sel_en, 1'b0);
        nxt();
        #1;
        chk("t2_sel_code", bus.sel_code, 8'h5A);
        chk("t2_sel_en", bus.sel_en, 1'b0);
        nxt();
        bus.bus_data = 1'b1;
        #1;
        chk("t3_sel_en", bus.sel_en, 1'b1);
        chk("t3_sel_code", bus.sel_code, 8'h5A);
        nxt();
        bus.bus_data = 1'b0;
        #1;
        chk("t4_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t4_rsp_data", bus.rsp_data, 1'b1);
        chk("t4_sel_en", bus.sel_en, 1'b0);
        nxt();
        #1;
        chk("t5_sel_code", bus.sel_code, 8'h00);
        chk("t5_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("t5_busy", bus.busy, 1'b0);

        // all four requesting continuously from reset
        RST = 1'b1;
        #1;
        RST = 1'b0;
        bus.req_code = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < 5; n++) begin
            nxt();
            bus.req_valid = 4'b1111;
            #1;
            chk("rr_ready", bus.req_ready, 4'b0001 << exp_g[n]);
            nxt();
            #1;
            chk("rr_sel_code", bus.sel_code, 8'h10 + exp_g[n]);
            nxt();
            nxt();
            bus.bus_data = n[0];
            #1;
            chk("rr_sel_en", bus.sel_en, 1'b1);
            nxt();
            #1;
            chk("rr_rsp_valid", bus.rsp_valid, 4'b0001 << exp_g[n]);
            chk("rr_rsp_data", bus.rsp_data, n[0]);
        end

        // grant to 2, then 0101 must wrap to requester 0
        nxt();
        bus.req_valid = 4'b0100;
        bus.bus_data  = 1'b1;
        #1;
        chk("rot_g2_ready", bus.req_ready, 4'b0100);
        nxt();
        bus.req_valid = 4'b0101;
        nxt();
        nxt();
        nxt();
        #1;
        chk("rot_g2_rsp", bus.rsp_valid, 4'b0100);
        nxt();
        #1;
        chk("rot_wrap_ready", bus.req_ready, 4'b0001);

        // requester 1 raises then withdraws while busy
        nxt();
        bus.req_valid = 4'b0010;
        #1;
        chk("wd_ready_busy", bus.req_ready, 4'b0000);
        nxt();
        bus.req_valid = 4'b0000;
        nxt();
        nxt();
        #1;
        chk("wd_rsp0", bus.rsp_valid, 4'b0001);
        nxt();
        #1;
        chk("wd_idle_ready", bus.req_ready, 4'b0000);
        chk("wd_idle_busy", bus.busy, 1'b0);
        nxt();
        nxt();
        #1;
        chk("wd_no_rsp", bus.rsp_valid, 4'b0000);
        chk("wd_still_idle", bus.busy, 1'b0);

        // reset in the middle of WAIT
        nxt();
        bus.req_valid = 4'b0100;
        #1;
        chk("mr_ready", bus.req_ready, 4'b0100);
        nxt();
        bus.req_valid = 4'b0000;
        nxt();
        #1;
        chk("mr_sel_code_wait", bus.sel_code, 8'h12);
        RST = 1'b1;
        #1;
        chk("mr_sel_code", bus.sel_code, 8'h00);
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_sel_en", bus.sel_en, 1'b0);
        #1;
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nxt();
            #1;
            chk("mr_no_rsp", bus.rsp_valid, 4'b0000);
        end
        nxt();
        bus.req_valid = 4'b1111;
        #1;
        chk("mr_ptr0_ready", bus.req_ready, 4'b0001);
        nxt();
        bus.req_valid = 4'b0000;
        nxt();
        nxt();
        nxt();
        #1;
        chk("mr_ptr0_rsp", bus.rsp_valid, 4'b0001);

        // bus_data toggles in WAIT, low in SAMPLE
        nxt();
        bus.req_valid = 4'b1000;
        bus.bus_data  = 1'b1;
        #1;
        chk("tg_ready", bus.req_ready, 4'b1000);
        nxt();
        bus.req_valid = 4'b0000;
        bus.bus_data  = 1'b0;
        #1;
        chk("tg_sel_code", bus.sel_code, 8'h13);
        nxt();
        bus.bus_data = 1'b1;
        nxt();
        bus.bus_data = 1'b0;
        #1;
        chk("tg_sel_en", bus.sel_en, 1'b1);
        nxt();
        bus.bus_data = 1'b1;
        #1;
        chk("tg_rsp_valid", bus.rsp_valid, 4'b1000);
        chk("tg_rsp_data", bus.rsp_data, 1'b0);
        nxt();
        #1;
        chk("tg_park", bus.sel_code, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
